enet_phy_gmii_bridge: RTL and testbench
=======================================

Name: enet_phy_gmii_bridge

Overview: Parametrised single-clock bridge between a narrow PHY-side data lane (1/2/4/8 bits per clock, SDR) and a byte-wide GMII-style stream with frame markers. RX path assembles lane words into bytes and flags the start, end and errors of each frame. TX path buffers bytes in a FIFO, serialises them onto the lane and enforces the inter-frame gap. It replaces the tie-off converter in the enet periph and sits between the MAC core and the PHY pad logic.

Parameters:
PHY_W, 4, lane width in bits; legal values are 1, 2, 4, 8; R = 8/PHY_W lane words per byte
TX_FIFO_DEPTH, 16, TX byte FIFO entries; power of 2, minimum 4; each entry is 8 data bits plus 1 last bit
TX_START_THRESH, 8, FIFO occupancy that starts transmission when no complete frame is queued; must be ≤ TX_FIFO_DEPTH
IFG_BYTES, 12, inter-frame gap in byte-times; gap = IFG_BYTES*R clocks

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
phy_rx_dv  in  1  RX lane data valid
phy_rx_er  in  1  RX lane error
phy_rxd  in  PHY_W  RX lane data; least-significant part of the byte arrives first
rx_byte_valid  out  1  one-cycle strobe; rx_byte, rx_sof, rx_eof and rx_err are valid while it is high
rx_byte  out  8  received byte
rx_sof  out  1  first byte of a frame
rx_eof  out  1  last byte of a frame
rx_err  out  1  frame error; qualified by rx_eof
tx_valid  in  1  TX byte offered
tx_ready  out  1  FIFO not full
tx_data  in  8  TX byte
tx_last  in  1  byte is the last of its frame
phy_tx_en  out  1  TX lane enable
phy_tx_er  out  1  TX lane error
phy_txd  out  PHY_W  TX lane data
rx_frame_cnt  out  16  count of good RX frames; saturates at 0xFFFF
rx_err_cnt  out  16  count of errored RX frames; saturates
tx_underrun_cnt  out  16  count of TX underruns; saturates

Behaviour:
- Reset: all outputs 0 except tx_ready=1. FIFO emptied, RX assembler and byte stage cleared, TX FSM returns to IDLE, all counters 0. Reset during a frame in progress aborts it immediately; phy_tx_en=0 from the cycle after the reset edge.
- RX assembler: while phy_rx_dv=1, slot index idx counts 0..R-1 and phy_rxd is written to byte bits [idx*PHY_W +: PHY_W].
- When idx=R-1 the completed byte moves into a one-byte stage. If the stage already holds a byte, the old byte is emitted in the same edge: rx_byte_valid=1, rx_sof=1 if it is the first byte of the frame, rx_eof=0.
- err_flag is sticky: it is set by phy_rx_er=1 at any cycle while dv=1.
- Frame end is the first cycle with dv=0 after dv=1. On that edge the staged byte is emitted with rx_eof=1, and with rx_sof=1 if it is also the first byte of the frame.
- rx_err on the eof beat = err_flag OR (idx≠0). A partial trailing byte is discarded.
- Counter update on frame end: rx_frame_cnt+1 if no error, otherwise rx_err_cnt+1.
- A frame that ends with no completed byte emits no beat and increments rx_err_cnt.
- idx, err_flag and the sof tracker clear at frame end.
- A new frame may start on the cycle right after dv falls; the eof beat of the old frame and the first nibble of the new frame do not conflict.
- TX FIFO: a push occurs when tx_valid && tx_ready. Push and pop may happen in the same cycle. tx_ready is derived from the registered count.
- TX FIFO tracks frames_q, the number of entries with last=1.
- TX FSM states and transitions:
  - IDLE: phy_tx_en=0. Start when frames_q>0 or count≥TX_START_THRESH. On start, pop a byte; phy_tx_en=1 and phy_txd = byte[PHY_W-1:0] on the next cycle.
  - DATA: one lane word per clock, LSB slice first, for R clocks per byte. After the final slice:
    - byte was last → IFG;
    - FIFO non-empty → pop the next byte with no gap;
    - FIFO empty → underrun: tx_underrun_cnt+1, then DRAIN.
  - DRAIN: phy_tx_en=1, phy_tx_er=1, phy_txd=0 for exactly R clocks. After that phy_tx_en=0. Pop and discard entries until one with last=1 is popped, then go to IFG. Pushes continue during DRAIN.
  - IFG: phy_tx_en=0, phy_tx_er=0 for IFG_BYTES*R clocks, then IDLE.
- phy_tx_er=0 outside DRAIN.
- All phy_tx_* outputs are registered.

Test Plan:
- PHY_W=4: dv=1 for 4 clocks with rxd 5,5,D,5 → beat 0x55 (sof=1), then beat 0x5D (eof=1, err=0) on the dv-fall edge; rx_frame_cnt=1.
- PHY_W=4: 3 nibbles A,B,C → single beat 0xBA with sof=eof=err=1; rx_err_cnt=1. Then 1 nibble only → no beat; rx_err_cnt=2.
- PHY_W=2: 8-slot frame with phy_rx_er=1 on slot 2 → two beats, eof beat has err=1; rx_frame_cnt unchanged.
- PHY_W=4: push 0x12, 0x34, 0x56(last) → txd 2,1,4,3,6,5 on 6 consecutive cycles with tx_en=1; then tx_en=0 for 24 clocks; a second queued frame starts on the next cycle.
- TX_START_THRESH=4: push 5 bytes without last, then stall → 5 bytes sent; tx_er=1 for 2 clocks; tx_underrun_cnt=1; later bytes up to and including last are discarded; no tx_en until the next frame.
- PHY_W=1, depth 16: 24 back-to-back pushes → tx_ready falls after the FIFO fills and recovers as the FIFO drains at 1 byte per 8 clocks; no byte is lost or duplicated. Assert rst mid-byte → tx_en=0 next cycle and all counters 0.

Source files
------------

// File: rtl/enet_phy_gmii_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : enet_phy_gmii_bridge
//  Brief    : Narrow PHY lane <-> byte-wide framed stream bridge with TX FIFO,
//             underrun drain and inter-frame gap enforcement.
//  Revision : 1.0 - initial release
// ============================================================================
module enet_phy_gmii_bridge #(
    parameter int PHY_W           = 4,
    parameter int TX_FIFO_DEPTH   = 16,
    parameter int TX_START_THRESH = 8,
    parameter int IFG_BYTES       = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phy_rx_dv,
    input  logic             phy_rx_er,
    input  logic [PHY_W-1:0] phy_rxd,
    output logic             rx_byte_valid,
    output logic [7:0]       rx_byte,
    output logic             rx_sof,
    output logic             rx_eof,
    output logic             rx_err,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,
    input  logic             tx_last,
    output logic             phy_tx_en,
    output logic             phy_tx_er,
    output logic [PHY_W-1:0] phy_txd,
    output logic [15:0]      rx_frame_cnt,
    output logic [15:0]      rx_err_cnt,
    output logic [15:0]      tx_underrun_cnt
);

    localparam int c_r     = 8 / PHY_W;
    localparam int c_idx_w = (c_r > 1) ? $clog2(c_r) : 1;
    localparam int c_aw    = $clog2(TX_FIFO_DEPTH);
    localparam int c_ifg   = IFG_BYTES * c_r;
    localparam int c_ifg_w = $clog2(c_ifg + 1);

    localparam logic [c_idx_w-1:0] c_last_slot = c_idx_w'(c_r - 1);
    localparam logic [c_ifg_w-1:0] c_ifg_last  = c_ifg_w'(c_ifg - 1);
    localparam logic [c_aw:0]      c_depth     = (c_aw + 1)'(TX_FIFO_DEPTH);
    localparam logic [c_aw:0]      c_thresh    = (c_aw + 1)'(TX_START_THRESH);

    // ------------------------------------------------------------------------
    // RX assembler and one-byte stage
    // ------------------------------------------------------------------------
    logic               r_in_frame;
    logic               r_err_flag;
    logic               r_sof_pend;
    logic [c_idx_w-1:0] r_idx;
    logic [7:0]         r_asm;
    logic               r_stage_vld;
    logic               r_stage_sof;
    logic [7:0]         r_stage;
    logic               r_rx_vld;
    logic [7:0]         r_rx_byte;
    logic               r_rx_sof;
    logic               r_rx_eof;
    logic               r_rx_err;
    logic [15:0]        r_frame_cnt;
    logic [15:0]        r_err_cnt;

    logic [7:0]         w_asm;
    logic               w_frame_bad;

    always_comb begin
        w_asm = r_asm;
        w_asm[int'(r_idx) * PHY_W +: PHY_W] = phy_rxd;
    end

    // An empty frame (no completed byte) counts as an error but emits nothing
    assign w_frame_bad = r_err_flag | (r_idx != '0) | ~r_stage_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_frame  <= 1'b0;
            r_err_flag  <= 1'b0;
            r_sof_pend  <= 1'b1;
            r_idx       <= '0;
            r_asm       <= '0;
            r_stage_vld <= 1'b0;
            r_stage_sof <= 1'b0;
            r_stage     <= '0;
            r_rx_vld    <= 1'b0;
            r_rx_byte   <= '0;
            r_rx_sof    <= 1'b0;
            r_rx_eof    <= 1'b0;
            r_rx_err    <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_rx_vld <= 1'b0;
            r_rx_sof <= 1'b0;
            r_rx_eof <= 1'b0;
            r_rx_err <= 1'b0;
            if (phy_rx_dv) begin
                r_in_frame <= 1'b1;
                r_asm      <= w_asm;
                if (phy_rx_er) begin
                    r_err_flag <= 1'b1;
                end
                if (r_idx == c_last_slot) begin
                    r_idx       <= '0;
                    r_stage     <= w_asm;
                    r_stage_vld <= 1'b1;
                    r_stage_sof <= r_sof_pend;
                    r_sof_pend  <= 1'b0;
                    if (r_stage_vld) begin
                        r_rx_vld  <= 1'b1;
                        r_rx_byte <= r_stage;
                        r_rx_sof  <= r_stage_sof;
                    end
                end else begin
                    r_idx <= r_idx + c_idx_w'(1);
                end
            end else if (r_in_frame) begin
                r_in_frame  <= 1'b0;
                r_err_flag  <= 1'b0;
                r_sof_pend  <= 1'b1;
                r_idx       <= '0;
                r_stage_vld <= 1'b0;
                if (r_stage_vld) begin
                    r_rx_vld  <= 1'b1;
                    r_rx_byte <= r_stage;
                    r_rx_sof  <= r_stage_sof;
                    r_rx_eof  <= 1'b1;
                    r_rx_err  <= w_frame_bad;
                end
                if (w_frame_bad) begin
                    r_err_cnt <= (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
                end else begin
                    r_frame_cnt <= (r_frame_cnt == 16'hFFFF) ? r_frame_cnt : r_frame_cnt + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // TX byte FIFO ({last, data} per entry)
    // ------------------------------------------------------------------------
    logic [8:0]      r_mem [TX_FIFO_DEPTH];
    logic [c_aw-1:0] r_wr;
    logic [c_aw-1:0] r_rd;
    logic [c_aw:0]   r_count;
    logic [c_aw:0]   r_frames;
    logic            w_push;
    logic            w_pop;
    logic [8:0]      w_head;

    assign tx_ready = (r_count != c_depth);
    assign w_push   = tx_valid & tx_ready;
    assign w_head   = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= {tx_last, tx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_count  <= '0;
            r_frames <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
            case ({w_push & tx_last, w_pop & w_head[8]})
                2'b10:   r_frames <= r_frames + (c_aw + 1)'(1);
                2'b01:   r_frames <= r_frames - (c_aw + 1)'(1);
                default: r_frames <= r_frames;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // TX serialiser FSM; all lane outputs come straight from registers
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_DRAIN = 2'd2,
        S_IFG   = 2'd3
    } tx_state_t;

    tx_state_t          r_state, w_state;
    logic [7:0]         r_byte, w_byte;
    logic               r_last, w_last;
    logic [c_idx_w-1:0] r_slot, w_slot;
    logic [c_idx_w-1:0] r_drain, w_drain;
    logic               r_found, w_found;
    logic [c_ifg_w-1:0] r_ifg, w_ifg;
    logic               r_tx_en, w_tx_en;
    logic               r_tx_er, w_tx_er;
    logic [PHY_W-1:0]   r_txd, w_txd;
    logic [15:0]        r_unr_cnt;
    logic               w_underrun;
    logic               w_launch;
    logic               w_start;

    assign w_start = (r_count != '0) && ((r_frames != '0) || (r_count >= c_thresh));

    always_comb begin
        w_state    = r_state;
        w_byte     = r_byte;
        w_last     = r_last;
        w_slot     = r_slot;
        w_drain    = r_drain;
        w_found    = r_found;
        w_ifg      = r_ifg;
        w_tx_en    = 1'b0;
        w_tx_er    = 1'b0;
        w_txd      = '0;
        w_pop      = 1'b0;
        w_underrun = 1'b0;
        w_launch   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_launch = w_start;
            end
            S_DATA: begin
                if (r_slot != c_last_slot) begin
                    w_slot  = r_slot + c_idx_w'(1);
                    w_tx_en = 1'b1;
                    w_txd   = r_byte[int'(w_slot) * PHY_W +: PHY_W];
                end else if (r_last) begin
                    w_state = S_IFG;
                    w_ifg   = '0;
                end else if (r_count != '0) begin
                    w_launch = 1'b1;
                end else begin
                    w_underrun = 1'b1;
                    w_state    = S_DRAIN;
                    w_tx_en    = 1'b1;
                    w_tx_er    = 1'b1;
                    w_drain    = '0;
                    w_found    = 1'b0;
                end
            end
            S_DRAIN: begin
                // Error marker lasts one byte-time; discarding runs until a last byte
                if (r_drain != c_last_slot) begin
                    w_drain = r_drain + c_idx_w'(1);
                    w_tx_en = 1'b1;
                    w_tx_er = 1'b1;
                end
                if (!r_found && (r_count != '0)) begin
                    w_pop   = 1'b1;
                    w_found = w_head[8];
                end
                if ((r_drain == c_last_slot) && w_found) begin
                    w_state = S_IFG;
                    w_ifg   = '0;
                end
            end
            S_IFG: begin
                if (r_ifg == c_ifg_last) begin
                    if (w_start) begin
                        w_launch = 1'b1;
                    end else begin
                        w_state = S_IDLE;
                    end
                end else begin
                    w_ifg = r_ifg + c_ifg_w'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
        if (w_launch) begin
            w_pop   = 1'b1;
            w_state = S_DATA;
            w_byte  = w_head[7:0];
            w_last  = w_head[8];
            w_slot  = '0;
            w_tx_en = 1'b1;
            w_txd   = w_head[PHY_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_byte    <= '0;
            r_last    <= 1'b0;
            r_slot    <= '0;
            r_drain   <= '0;
            r_found   <= 1'b0;
            r_ifg     <= '0;
            r_tx_en   <= 1'b0;
            r_tx_er   <= 1'b0;
            r_txd     <= '0;
            r_unr_cnt <= '0;
        end else begin
            r_state <= w_state;
            r_byte  <= w_byte;
            r_last  <= w_last;
            r_slot  <= w_slot;
            r_drain <= w_drain;
            r_found <= w_found;
            r_ifg   <= w_ifg;
            r_tx_en <= w_tx_en;
            r_tx_er <= w_tx_er;
            r_txd   <= w_txd;
            if (w_underrun) begin
                r_unr_cnt <= (r_unr_cnt == 16'hFFFF) ? r_unr_cnt : r_unr_cnt + 16'd1;
            end
        end
    end

    assign rx_byte_valid   = r_rx_vld;
    assign rx_byte         = r_rx_byte;
    assign rx_sof          = r_rx_sof;
    assign rx_eof          = r_rx_eof;
    assign rx_err          = r_rx_err;
    assign phy_tx_en       = r_tx_en;
    assign phy_tx_er       = r_tx_er;
    assign phy_txd         = r_txd;
    assign rx_frame_cnt    = r_frame_cnt;
    assign rx_err_cnt      = r_err_cnt;
    assign tx_underrun_cnt = r_unr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_enet_phy_gmii_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enet_phy_gmii_bridge
//  Brief    : Scoreboard bench for enet_phy_gmii_bridge with randomized frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_enet_phy_gmii_bridge;

    localparam int PHY_W  = 4;
    localparam int DEPTH  = 16;
    localparam int THRESH = 4;
    localparam int IFG    = 12;
    localparam int R      = 8 / PHY_W;
    localparam int C_IFG  = IFG * R;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             phy_rx_dv = 1'b0;
    logic             phy_rx_er = 1'b0;
    logic [PHY_W-1:0] phy_rxd = '0;
    logic             rx_byte_valid;
    logic [7:0]       rx_byte;
    logic             rx_sof, rx_eof, rx_err;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic [7:0]       tx_data = '0;
    logic             tx_last = 1'b0;
    logic             phy_tx_en, phy_tx_er;
    logic [PHY_W-1:0] phy_txd;
    logic [15:0]      rx_frame_cnt, rx_err_cnt, tx_underrun_cnt;

    always #5 clk = ~clk;

    enet_phy_gmii_bridge #(
        .PHY_W(PHY_W), .TX_FIFO_DEPTH(DEPTH), .TX_START_THRESH(THRESH), .IFG_BYTES(IFG)
    ) dut (
        .clk(clk), .rst(rst),
        .phy_rx_dv(phy_rx_dv), .phy_rx_er(phy_rx_er), .phy_rxd(phy_rxd),
        .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte), .rx_sof(rx_sof),
        .rx_eof(rx_eof), .rx_err(rx_err),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .phy_tx_en(phy_tx_en), .phy_tx_er(phy_tx_er), .phy_txd(phy_txd),
        .rx_frame_cnt(rx_frame_cnt), .rx_err_cnt(rx_err_cnt), .tx_underrun_cnt(tx_underrun_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [10:0]    rx_exp_q[$];   // {err, eof, sof, byte}
    logic [PHY_W:0] tx_exp_q[$];   // {er, txd}
    int             gaps_q[$];
    bit             mon_on = 1'b0;
    bit             seen_frame = 1'b0;
    bit             ready_low_seen = 1'b0;
    int             gap_run = 0;
    int             exp_frames = 0;
    int             exp_errs = 0;
    int             exp_unr = 0;

    task automatic check_eq(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // RX monitor
    always @(negedge clk) begin
        if (mon_on && rx_byte_valid) begin
            if (rx_exp_q.size() == 0) begin
                check_eq("rx_unexpected_beat", {rx_err, rx_eof, rx_sof, rx_byte}, 0);
            end else begin
                check_eq("rx_beat", {rx_err, rx_eof, rx_sof, rx_byte}, rx_exp_q.pop_front());
            end
        end
    end

    // TX monitor
    always @(negedge clk) begin
        if (mon_on) begin
            if (phy_tx_en) begin
                if (seen_frame && gap_run > 0) begin
                    gaps_q.push_back(gap_run);
                    check_eq("tx_ifg_min", (gap_run >= C_IFG), 1);
                end
                gap_run    = 0;
                seen_frame = 1'b1;
                if (tx_exp_q.size() == 0) begin
                    check_eq("tx_unexpected_word", {phy_tx_er, phy_txd}, 0);
                end else begin
                    check_eq("tx_word", {phy_tx_er, phy_txd}, tx_exp_q.pop_front());
                end
            end else begin
                gap_run++;
                check_eq("tx_er_idle", phy_tx_er, 0);
            end
        end
    end

    // RX reference: slots form bytes LSB-first; any error, partial or empty frame is bad
    task automatic rx_frame(input logic [PHY_W-1:0] slots[$], input int er_slot, input int gap);
        int  n      = slots.size();
        int  nbytes = n / R;
        bit  bad    = (er_slot >= 0 && er_slot < n) || (n % R != 0) || (nbytes == 0);
        for (int b = 0; b < nbytes; b++) begin
            int v = 0;
            for (int k = 0; k < R; k++) v = v | (int'(slots[b*R+k]) << (k * PHY_W));
            rx_exp_q.push_back({(b == nbytes - 1) && bad, b == nbytes - 1, b == 0, 8'(v)});
        end
        if (bad) exp_errs++;
        else exp_frames++;
        for (int i = 0; i < n; i++) begin
            phy_rx_dv = 1'b1;
            phy_rxd   = slots[i];
            phy_rx_er = (i == er_slot);
            @(negedge clk);
        end
        phy_rx_dv = 1'b0;
        phy_rx_er = 1'b0;
        phy_rxd   = PHY_W'($urandom);
        @(negedge clk);
        check_eq("rx_frame_cnt", rx_frame_cnt, exp_frames);
        check_eq("rx_err_cnt", rx_err_cnt, exp_errs);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic rx_seq();
        logic [PHY_W-1:0] q[$];
        @(negedge clk);
        q = '{4'h5, 4'h5, 4'hD, 4'h5};  rx_frame(q, -1, 1);
        q = '{4'hA, 4'hB, 4'hC};        rx_frame(q, -1, 1);
        q = '{4'h1};                    rx_frame(q, -1, 2);
        q = '{4'h3, 4'h9, 4'h7, 4'hE};  rx_frame(q, 2, 1);
        for (int f = 0; f < 30; f++) begin
            int n = $urandom_range(1, 24);
            int e = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(PHY_W'($urandom));
            rx_frame(q, e, $urandom_range(1, 4));
        end
    endtask

    // mode 0: frame expected on lane; 1: prefix that underruns; 2: bytes expected discarded
    task automatic push_frame(input logic [7:0] bytes[$], input bit with_last, input int mode);
        int n = bytes.size();
        if (mode != 2) begin
            foreach (bytes[i])
                for (int k = 0; k < R; k++)
                    tx_exp_q.push_back({1'b0, PHY_W'((int'(bytes[i]) >> (k * PHY_W)) & ((1 << PHY_W) - 1))});
        end
        if (mode == 1) begin
            for (int k = 0; k < R; k++) tx_exp_q.push_back({1'b1, {PHY_W{1'b0}}});
            exp_unr++;
        end
        for (int i = 0; i < n; i++) begin
            int w = 0;
            tx_valid = 1'b1;
            tx_data  = bytes[i];
            tx_last  = with_last && (i == n - 1);
            while (!tx_ready && w < 2000) begin
                ready_low_seen = 1'b1;
                @(negedge clk);
                w++;
            end
            if (!tx_ready) check_eq("tx_ready_timeout", tx_ready, 1);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int w = 0;
        while ((tx_exp_q.size() != 0 || phy_tx_en) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) check_eq("tx_idle_timeout", tx_exp_q.size(), 0);
        repeat (C_IFG + 4) @(negedge clk);
    endtask

    task automatic rand_bytes(output logic [7:0] q[$], input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endtask

    task automatic tx_seq();
        logic [7:0] b[$];
        @(negedge clk);
        b = '{8'h12, 8'h34, 8'h56};
        push_frame(b, 1'b1, 0);
        rand_bytes(b, 2);
        push_frame(b, 1'b1, 0);
        wait_tx_idle();
        rand_bytes(b, 5);
        push_frame(b, 1'b0, 1);
        repeat (60) @(negedge clk);
        rand_bytes(b, 3);
        push_frame(b, 1'b1, 2);
        wait_tx_idle();
        for (int f = 0; f < 12; f++) begin
            rand_bytes(b, $urandom_range(1, 12));
            push_frame(b, 1'b1, 0);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        rand_bytes(b, 40);
        push_frame(b, 1'b1, 0);
        wait_tx_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b[$];
        int w;
        repeat (3) @(negedge clk);
        check_eq("reset_tx_ready", tx_ready, 1);
        check_eq("reset_tx_en", phy_tx_en, 0);
        check_eq("reset_tx_er", phy_tx_er, 0);
        check_eq("reset_txd", phy_txd, 0);
        check_eq("reset_rx_valid", rx_byte_valid, 0);
        check_eq("reset_cnts", {rx_frame_cnt, rx_err_cnt, tx_underrun_cnt}, 0);
        rst    = 1'b0;
        mon_on = 1'b1;

        fork
            rx_seq();
            tx_seq();
        join

        w = 0;
        while ((rx_exp_q.size() != 0 || tx_exp_q.size() != 0) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check_eq("rx_queue_drained", rx_exp_q.size(), 0);
        check_eq("tx_queue_drained", tx_exp_q.size(), 0);
        check_eq("final_rx_frame_cnt", rx_frame_cnt, exp_frames);
        check_eq("final_rx_err_cnt", rx_err_cnt, exp_errs);
        check_eq("final_tx_underrun_cnt", tx_underrun_cnt, exp_unr);
        check_eq("tx_backpressure_seen", ready_low_seen, 1);
        check_eq("first_gap_recorded", (gaps_q.size() > 0), 1);
        if (gaps_q.size() > 0) check_eq("back_to_back_ifg", gaps_q[0], C_IFG);

        // Reset in the middle of a byte
        mon_on = 1'b0;
        rand_bytes(b, 4);
        push_frame(b, 1'b1, 2);
        w = 0;
        while (!phy_tx_en && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("reset_test_tx_started", phy_tx_en, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midreset_tx_en", phy_tx_en, 0);
        check_eq("midreset_tx_er", phy_tx_er, 0);
        check_eq("midreset_tx_ready", tx_ready, 1);
        check_eq("midreset_cnts", {rx_frame_cnt, rx_err_cnt, tx_underrun_cnt}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("post_reset_fifo_empty_no_tx", phy_tx_en, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
